// File: rtl/demux_de_control_forzado_pkg.sv
// Shared lane constants for the forced-control mux/demux pair: control bytes, decoded codes and FSM states.
// Both ends of the link import this package so that they agree on every encoding.
package demux_de_control_forzado_pkg;

    localparam logic [7:0] K_COM    = 8'hBC;
    localparam logic [7:0] K_PAD    = 8'hF7;
    localparam logic [7:0] K_SKP    = 8'h1C;
    localparam logic [7:0] K_STP    = 8'hFB;
    localparam logic [7:0] K_END    = 8'hFD;
    localparam logic [7:0] K_IDL    = 8'h7C;
    localparam logic [7:0] K_FORCED = 8'hFF;

    localparam logic [3:0] C_NONE   = 4'h0;
    localparam logic [3:0] C_COM    = 4'h1;
    localparam logic [3:0] C_PAD    = 4'h2;
    localparam logic [3:0] C_SKP    = 4'h3;
    localparam logic [3:0] C_STP    = 4'h4;
    localparam logic [3:0] C_END    = 4'h5;
    localparam logic [3:0] C_IDL    = 4'h6;
    localparam logic [3:0] C_FORCED = 4'hF;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/demux_de_control_forzado_if.sv
// Lane-side bundle of the forced-control demux: one received byte in, recovered stream and sync status out.
interface demux_de_control_forzado_if;

    // No backpressure: IN is consumed on every CLK edge and VALID qualifies OUT on the following cycle.
    logic [7:0] IN;
    logic [7:0] OUT;
    logic       VALID;
    logic [3:0] CONTROL;
    logic       SYNC;
    logic       ERROR;

    modport master (output IN, input OUT, VALID, CONTROL, SYNC, ERROR);
    modport slave  (input IN, output OUT, VALID, CONTROL, SYNC, ERROR);

endinterface

// File: rtl/demux_de_control_forzado_decodificador_control.sv
// Combinational classifier: lane byte -> {is_ctrl, code}. Any byte outside the control table is data.
module decodificador_control
    import demux_de_control_forzado_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_ctrl,
    output logic [3:0] o_code
);

    always_comb begin
        o_code = C_NONE;
        case (i_byte)
            K_COM:    o_code = C_COM;
            K_PAD:    o_code = C_PAD;
            K_SKP:    o_code = C_SKP;
            K_STP:    o_code = C_STP;
            K_END:    o_code = C_END;
            K_IDL:    o_code = C_IDL;
            K_FORCED: o_code = C_FORCED;
            default:  o_code = C_NONE;
        endcase
    end

    assign o_is_ctrl = (o_code != C_NONE);

endmodule

// File: rtl/demux_de_control_forzado.sv
// Receive-side forced-control demux: acquires lane lock on COM runs, splits data from control bytes
// and drops lock (one-cycle ERROR) when no COM is seen for COM_TIMEOUT cycles.
module demux_de_control_forzado
    import demux_de_control_forzado_pkg::*;
#(
    parameter int LOCK_COUNT  = 4,
    parameter int COM_TIMEOUT = 64
) (
    input  logic                        CLK,
    input  logic                        RESET,
    demux_de_control_forzado_if.slave   bus,
    output state_t                      o_dbg_state
);

    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int TW = $clog2(COM_TIMEOUT);
    localparam logic [CW-1:0] LOCK_CNT_V = CW'(LOCK_COUNT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(COM_TIMEOUT - 1);

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_com_cnt, w_com_nx;
    logic [TW-1:0] r_tmo_cnt, w_tmo_nx;
    logic [7:0]    r_out, w_out_nx;
    logic          r_valid, w_valid_nx;
    logic [3:0]    r_ctrl, w_ctrl_nx;
    logic          r_sync;
    logic          r_err, w_err_nx;

    logic          w_is_ctrl;
    logic [3:0]    w_code;
    logic          w_is_com;

    decodificador_control u_dec (
        .i_byte    (bus.IN),
        .o_is_ctrl (w_is_ctrl),
        .o_code    (w_code)
    );

    assign w_is_com = w_is_ctrl && (w_code == C_COM);

    always_comb begin
        w_state_nx = r_state;
        w_com_nx   = r_com_cnt;
        w_tmo_nx   = r_tmo_cnt;
        w_out_nx   = 8'h00;
        w_valid_nx = 1'b0;
        w_ctrl_nx  = C_NONE;
        w_err_nx   = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_is_com) begin
                    w_com_nx = CW'(1);
                    w_tmo_nx = '0;
                    w_state_nx = (LOCK_COUNT == 1) ? ST_LOCKED : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (!w_is_com) begin
                    w_state_nx = ST_SEARCH;
                    w_com_nx   = '0;
                end else if (r_com_cnt == LOCK_CNT_V - CW'(1)) begin
                    w_state_nx = ST_LOCKED;
                    w_com_nx   = LOCK_CNT_V;
                    w_tmo_nx   = '0;
                end else begin
                    w_com_nx = r_com_cnt + CW'(1);
                end
            end
            ST_LOCKED: begin
                // A COM on the timeout cycle still refreshes the lock.
                if (w_is_com) begin
                    w_tmo_nx  = '0;
                    w_ctrl_nx = C_COM;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nx = ST_SEARCH;
                    w_com_nx   = '0;
                    w_tmo_nx   = '0;
                    w_err_nx   = 1'b1;
                end else begin
                    w_tmo_nx = r_tmo_cnt + TW'(1);
                    if (w_is_ctrl) begin
                        w_ctrl_nx = w_code;
                    end else begin
                        w_out_nx   = bus.IN;
                        w_valid_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = ST_SEARCH;
                w_com_nx   = '0;
                w_tmo_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_SEARCH;
            r_com_cnt <= '0;
            r_tmo_cnt <= '0;
            r_out     <= 8'h00;
            r_valid   <= 1'b0;
            r_ctrl    <= C_NONE;
            r_sync    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_com_cnt <= w_com_nx;
            r_tmo_cnt <= w_tmo_nx;
            r_out     <= w_out_nx;
            r_valid   <= w_valid_nx;
            r_ctrl    <= w_ctrl_nx;
            r_sync    <= (w_state_nx == ST_LOCKED);
            r_err     <= w_err_nx;
        end
    end

    assign bus.OUT     = r_out;
    assign bus.VALID   = r_valid;
    assign bus.CONTROL = r_ctrl;
    assign bus.SYNC    = r_sync;
    assign bus.ERROR   = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_demux_de_control_forzado.sv
// Bench for the forced-control demux: directed lock/timeout/race cases, random bytes against a
// behavioural lane model, and a forced-mux loopback scoreboard.
module tb_demux_de_control_forzado;
    import demux_de_control_forzado_pkg::*;

    localparam int LOCK_COUNT  = 4;
    localparam int COM_TIMEOUT = 64;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;
    always #5 clk = ~clk;

    demux_de_control_forzado_if bus ();

    demux_de_control_forzado #(
        .LOCK_COUNT  (LOCK_COUNT),
        .COM_TIMEOUT (COM_TIMEOUT)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit lb_en  = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ctrl_code(input logic [7:0] b);
        case (b)
            8'hBC: return 4'h1;
            8'hF7: return 4'h2;
            8'h1C: return 4'h3;
            8'hFB: return 4'h4;
            8'hFD: return 4'h5;
            8'h7C: return 4'h6;
            8'hFF: return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [7:0] rand_data();
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        while (ctrl_code(d) != 4'h0) d = 8'($urandom_range(0, 255));
        return d;
    endfunction

    // ---------------- behavioural lane model ----------------
    // locked flag, length of current COM run while unlocked, non-COM bytes since last COM while locked.
    bit         m_locked = 1'b0;
    int         m_run    = 0;
    int         m_since  = 0;
    logic [7:0] exp_out   = 8'h00;
    logic       exp_valid = 1'b0;
    logic [3:0] exp_ctrl  = 4'h0;
    logic       exp_sync  = 1'b0;
    logic       exp_err   = 1'b0;

    task automatic model_step(input logic [7:0] b);
        logic [3:0] code;
        code = ctrl_code(b);
        exp_out = 8'h00; exp_valid = 1'b0; exp_ctrl = 4'h0; exp_err = 1'b0;
        if (!m_locked) begin
            if (b == 8'hBC) begin
                m_run++;
                if (m_run >= LOCK_COUNT) begin m_locked = 1'b1; m_since = 0; end
            end else begin
                m_run = 0;
            end
        end else if (b == 8'hBC) begin
            m_since = 0;
            exp_ctrl = 4'h1;
        end else if (m_since == COM_TIMEOUT - 1) begin
            m_locked = 1'b0;
            m_run = 0;
            exp_err = 1'b1;
        end else begin
            m_since++;
            if (code == 4'h0) begin exp_out = b; exp_valid = 1'b1; end
            else exp_ctrl = code;
        end
        exp_sync = m_locked;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_locked = 1'b0; m_run = 0; m_since = 0;
            exp_out = 8'h00; exp_valid = 1'b0; exp_ctrl = 4'h0; exp_sync = 1'b0; exp_err = 1'b0;
        end else begin
            model_step(bus.IN);
        end
    end

    // ---------------- compare process + loopback scoreboard ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("OUT", 32'(bus.OUT), 32'(exp_out));
            check("VALID", 32'(bus.VALID), 32'(exp_valid));
            check("CONTROL", 32'(bus.CONTROL), 32'(exp_ctrl));
            check("SYNC", 32'(bus.SYNC), 32'(exp_sync));
            check("ERROR", 32'(bus.ERROR), 32'(exp_err));
            check("STATE_LOCKED", 32'(dbg_state == ST_LOCKED), 32'(exp_sync));
            if (lb_en && bus.VALID) begin
                if (exp_q.size() == 0) check("LB_UNEXPECTED", 32'(bus.OUT), 32'hFFFF_FFFF);
                else check("LB_DATA", 32'(bus.OUT), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; returns at the next negedge with the DUT outputs reflecting b.
    task automatic send(input logic [7:0] b);
        bus.IN = b;
        @(negedge clk);
    endtask

    task automatic send_com_run(input int n);
        for (int i = 0; i < n; i++) send(8'hBC);
    endtask

    task automatic send_data_run(input int n);
        for (int i = 0; i < n; i++) send(rand_data());
    endtask

    task automatic forced_mux_send(input bit v, input logic [7:0] d);
        if (v) begin
            exp_q.push_back(d);
            send(d);
        end else begin
            send(8'hFF);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.IN = 8'h00;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("RST_OUT", 32'(bus.OUT), 32'h0);
        check("RST_VALID", 32'(bus.VALID), 32'h0);
        check("RST_CONTROL", 32'(bus.CONTROL), 32'h0);
        check("RST_SYNC", 32'(bus.SYNC), 32'h0);
        check("RST_ERROR", 32'(bus.ERROR), 32'h0);
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Lock acquisition
        send_com_run(3);
        check("LOCK_SYNC_3COM", 32'(bus.SYNC), 32'h0);
        send(8'hBC);
        check("LOCK_SYNC_4COM", 32'(bus.SYNC), 32'h1);
        check("LOCK_MODEL_SYNC", 32'(exp_sync), 32'h1);
        check("LOCK_CTRL_4COM", 32'(bus.CONTROL), 32'h0);
        send(8'h55);
        check("LOCK_DATA_OUT", 32'(bus.OUT), 32'h55);
        check("LOCK_DATA_VALID", 32'(bus.VALID), 32'h1);

        // Forced control and idle
        send(8'hFF);
        check("FORCED_CTRL", 32'(bus.CONTROL), 32'hF);
        check("FORCED_VALID", 32'(bus.VALID), 32'h0);
        send(8'h7C);
        check("IDL_CTRL", 32'(bus.CONTROL), 32'h6);
        send(8'hA3);
        check("A3_OUT", 32'(bus.OUT), 32'hA3);
        check("A3_VALID", 32'(bus.VALID), 32'h1);
        check("A3_CTRL", 32'(bus.CONTROL), 32'h0);

        // COM on the timeout cycle keeps lock
        send(8'hBC);
        check("COM_CTRL", 32'(bus.CONTROL), 32'h1);
        send_data_run(COM_TIMEOUT - 1);
        send(8'hBC);
        check("RACE_SYNC", 32'(bus.SYNC), 32'h1);
        check("RACE_ERROR", 32'(bus.ERROR), 32'h0);
        check("RACE_CTRL", 32'(bus.CONTROL), 32'h1);

        // Timeout: the 64th byte without COM drops lock
        send_data_run(COM_TIMEOUT - 1);
        check("TMO_SYNC_BEFORE", 32'(bus.SYNC), 32'h1);
        check("TMO_VALID_BEFORE", 32'(bus.VALID), 32'h1);
        send(8'h42);
        check("TMO_SYNC", 32'(bus.SYNC), 32'h0);
        check("TMO_ERROR", 32'(bus.ERROR), 32'h1);
        check("TMO_VALID", 32'(bus.VALID), 32'h0);
        check("TMO_OUT", 32'(bus.OUT), 32'h0);
        send(8'h43);
        check("TMO_ERROR_1CYC", 32'(bus.ERROR), 32'h0);
        check("TMO_VALID_AFTER", 32'(bus.VALID), 32'h0);

        // Aborted alignment restarts the count
        send_com_run(2);
        send(8'h12);
        check("ABORT_SYNC", 32'(bus.SYNC), 32'h0);
        check("ABORT_ERROR", 32'(bus.ERROR), 32'h0);
        send_com_run(3);
        check("ABORT_RESTART_3", 32'(bus.SYNC), 32'h0);
        send(8'hBC);
        check("ABORT_RESTART_4", 32'(bus.SYNC), 32'h1);

        // Asynchronous reset mid-stream
        send(8'h66);
        check("PRE_RST_VALID", 32'(bus.VALID), 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ARST_OUT", 32'(bus.OUT), 32'h0);
        check("ARST_VALID", 32'(bus.VALID), 32'h0);
        check("ARST_CONTROL", 32'(bus.CONTROL), 32'h0);
        check("ARST_SYNC", 32'(bus.SYNC), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h77);
        check("ARST_NO_RELOCK", 32'(bus.SYNC), 32'h0);

        // Random lane bytes against the model
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 3) send(8'hBC);
            else if (sel <= 5) begin
                logic [7:0] tbl[7];
                tbl = '{8'hBC, 8'hF7, 8'h1C, 8'hFB, 8'hFD, 8'h7C, 8'hFF};
                send(tbl[$urandom_range(0, 6)]);
            end else send(8'($urandom_range(0, 255)));
        end

        // Loopback through a forced-control mux with random VALID pattern
        send(8'h00);
        send_com_run(LOCK_COUNT);
        check("LB_LOCKED", 32'(bus.SYNC), 32'h1);
        lb_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ((i % 16) == 15) send(8'hBC);
            else forced_mux_send(1'($urandom_range(0, 1)), rand_data());
        end
        send(8'hFF);
        send(8'hFF);
        lb_en = 1'b0;
        check("LB_QUEUE_EMPTY", 32'(exp_q.size()), 32'h0);
        check("LB_SYNC_KEPT", 32'(bus.SYNC), 32'h1);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
